// File: rtl/x_oser_int.sv
// x_oser_int: multi-channel parallel-to-serial output stage with registered Q and gapless word chaining.
// Define X_OSER_UNDERRUN_CNT_EN to add the saturating UNDERRUN_CNT output.
module x_oser_int #(
    parameter int   CHANNELS  = 1,
    parameter int   RATIO     = 4,
    parameter logic INIT      = 1'b0,
    parameter int   LSB_FIRST = 1
) (
    input  logic                      C,
    input  logic                      R_N,
    input  logic                      CE,
    input  logic [CHANNELS*RATIO-1:0] D,
    input  logic                      D_VALID,
    output logic                      D_READY,
    output logic [CHANNELS-1:0]       Q,
    output logic                      Q_VALID,
    output logic                      UNDERRUN
`ifdef X_OSER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]                UNDERRUN_CNT
`endif
);

    localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    generate
        if (RATIO < 2 || RATIO > 8 || CHANNELS < 1 || CHANNELS > 16) begin : g_bad_param
            $fatal(1, "x_oser_int: RATIO must be 2..8 and CHANNELS 1..16");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [CHANNELS-1:0][RATIO-1:0] sh_q, sh_d;
    logic [CHANNELS-1:0]            q_q, q_d;
    logic                           q_valid_q, q_valid_d;
    logic                           underrun_q, underrun_d;
    logic                           at_last;
    logic                           accept;

    assign at_last = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    assign D_READY = R_N && CE && ((state_q == ST_IDLE) || at_last);
    assign accept  = D_READY && D_VALID;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        q_d        = q_q;
        q_valid_d  = q_valid_q;
        underrun_d = 1'b0;
        if (CE) begin
            if (accept) begin
                // The first slot goes straight to Q; the shifter keeps only the remaining slots.
                state_d   = ST_SHIFT;
                cnt_d     = '0;
                q_valid_d = 1'b1;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (LSB_FIRST != 0) begin
                        q_d[c]  = D[c*RATIO];
                        sh_d[c] = D[c*RATIO +: RATIO] >> 1;
                    end else begin
                        q_d[c]  = D[c*RATIO + RATIO - 1];
                        sh_d[c] = D[c*RATIO +: RATIO] << 1;
                    end
                end
            end else if (at_last) begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                q_d        = {CHANNELS{INIT}};
                q_valid_d  = 1'b0;
                underrun_d = 1'b1;
            end else if (state_q == ST_SHIFT) begin
                cnt_d = cnt_q + CNT_W'(1);
                for (int c = 0; c < CHANNELS; c++) begin
                    if (LSB_FIRST != 0) begin
                        q_d[c]  = sh_q[c][0];
                        sh_d[c] = sh_q[c] >> 1;
                    end else begin
                        q_d[c]  = sh_q[c][RATIO-1];
                        sh_d[c] = sh_q[c] << 1;
                    end
                end
            end
        end
    end

    always_ff @(posedge C) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
        if (!R_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            q_q        <= {CHANNELS{INIT}};
            q_valid_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
            underrun_q <= underrun_d;
        end
    end

    assign Q        = q_q;
    assign Q_VALID  = q_valid_q;
    assign UNDERRUN = underrun_q;

`ifdef X_OSER_UNDERRUN_CNT_EN
    logic [7:0] ucnt_q, ucnt_d;

    // underrun_d is already forced low while CE=0, so the count holds then.
    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_d && (ucnt_q != 8'hFF)) begin
            ucnt_d = ucnt_q + 8'd1;
        end
    end

    always_ff @(posedge C) begin
        if (!R_N) begin
            ucnt_q <= 8'd0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign UNDERRUN_CNT = ucnt_q;
`endif

endmodule

// File: tb/tb_x_oser_int.sv
// Scoreboard bench for x_oser_int: LSB-first and MSB-first instances share stimulus and a stream-level model.
module tb_x_oser_int;

    localparam int   CH   = 2;
    localparam int   RT   = 4;
    localparam int   W    = CH * RT;
    localparam logic INIT = 1'b1;

    logic          C = 1'b0;
    logic          R_N = 1'b0;
    logic          CE = 1'b0;
    logic          D_VALID = 1'b0;
    logic [W-1:0]  D = '0;
    logic          rdy_l, qv_l, ur_l, rdy_m, qv_m, ur_m;
    logic [CH-1:0] q_l, q_m;
`ifdef X_OSER_UNDERRUN_CNT_EN
    logic [7:0]    ucnt_l, ucnt_m;
`endif

    x_oser_int #(.CHANNELS(CH), .RATIO(RT), .INIT(INIT), .LSB_FIRST(1)) dut_lsb (
        .C(C), .R_N(R_N), .CE(CE), .D(D), .D_VALID(D_VALID), .D_READY(rdy_l),
        .Q(q_l), .Q_VALID(qv_l), .UNDERRUN(ur_l)
`ifdef X_OSER_UNDERRUN_CNT_EN
        , .UNDERRUN_CNT(ucnt_l)
`endif
    );

    x_oser_int #(.CHANNELS(CH), .RATIO(RT), .INIT(INIT), .LSB_FIRST(0)) dut_msb (
        .C(C), .R_N(R_N), .CE(CE), .D(D), .D_VALID(D_VALID), .D_READY(rdy_m),
        .Q(q_m), .Q_VALID(qv_m), .UNDERRUN(ur_m)
`ifdef X_OSER_UNDERRUN_CNT_EN
        , .UNDERRUN_CNT(ucnt_m)
`endif
    );

    always #5 C = ~C;

    int checks = 0;
    int failures = 0;

    // Stream model: number of payload bits still queued behind the one on Q.
    int  m_pending = 0;
    bit  m_valid = 1'b0;
    bit  m_under = 1'b0;
    int  m_ucnt = 0;
    logic [CH-1:0] sb_l[$];
    logic [CH-1:0] sb_m[$];
    logic [CH-1:0] last_l = '0;
    logic [CH-1:0] last_m = '0;
    bit  edge_act = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return R_N && CE && (m_pending == 0);
    endfunction

    task automatic model_step(input bit acc, input logic [W-1:0] d);
        logic [CH-1:0] vl, vm;
        if (!R_N) begin
            m_pending = 0;
            m_valid   = 1'b0;
            m_under   = 1'b0;
            m_ucnt    = 0;
            sb_l.delete();
            sb_m.delete();
        end else if (!CE) begin
            m_under = 1'b0;
        end else if (acc) begin
            for (int k = 0; k < RT; k++) begin
                for (int c = 0; c < CH; c++) begin
                    vl[c] = d[c*RT + k];
                    vm[c] = d[c*RT + (RT - 1 - k)];
                end
                sb_l.push_back(vl);
                sb_m.push_back(vm);
            end
            m_pending = RT - 1;
            m_valid   = 1'b1;
            m_under   = 1'b0;
        end else if (m_pending > 0) begin
            m_pending--;
            m_under = 1'b0;
        end else if (m_valid) begin
            m_valid = 1'b0;
            m_under = 1'b1;
            if (m_ucnt < 255) m_ucnt++;
        end else begin
            m_under = 1'b0;
        end
    endtask

    task automatic cycle(input bit r_n, input bit ce, input bit dv, input logic [W-1:0] d,
                         output bit acc);
        bit rdy;
        R_N     = r_n;
        CE      = ce;
        D_VALID = dv;
        D       = d;
        #1;
        rdy = model_ready();
        check("d_ready_lsb", {31'd0, rdy_l}, {31'd0, rdy});
        check("d_ready_msb", {31'd0, rdy_m}, {31'd0, rdy});
        acc = rdy && dv;
        @(posedge C);
        model_step(acc, d);
        @(negedge C);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b1, 1'b1, 1'b0, '0, acc);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        bit acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, 1'b1, 1'b1, w, acc);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: word %0h not accepted within 20 cycles", w);
        end
    endtask

    always @(posedge C) edge_act <= R_N && CE;

    always @(negedge C) begin
        check("q_valid_lsb", {31'd0, qv_l}, {31'd0, m_valid});
        check("q_valid_msb", {31'd0, qv_m}, {31'd0, m_valid});
        check("underrun_lsb", {31'd0, ur_l}, {31'd0, m_under});
        check("underrun_msb", {31'd0, ur_m}, {31'd0, m_under});
`ifdef X_OSER_UNDERRUN_CNT_EN
        check("ucnt_lsb", {24'd0, ucnt_l}, m_ucnt);
        check("ucnt_msb", {24'd0, ucnt_m}, m_ucnt);
`endif
        if (qv_l) begin
            if (edge_act) begin
                if (sb_l.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL q_lsb_extra: got %0h expected no payload at %0t", q_l, $time);
                end else begin
                    last_l = sb_l.pop_front();
                end
            end
            check("q_lsb", {30'd0, q_l}, {30'd0, last_l});
        end else begin
            check("q_idle_lsb", {30'd0, q_l}, {30'd0, {CH{INIT}}});
        end
        if (qv_m) begin
            if (edge_act) begin
                if (sb_m.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL q_msb_extra: got %0h expected no payload at %0t", q_m, $time);
                end else begin
                    last_m = sb_m.pop_front();
                end
            end
            check("q_msb", {30'd0, q_m}, {30'd0, last_m});
        end else begin
            check("q_idle_msb", {30'd0, q_m}, {30'd0, {CH{INIT}}});
        end
    end

    initial begin
        bit acc;
        // Reset for three cycles, then idle with D_VALID low.
        repeat (3) cycle(1'b0, 1'b1, 1'b0, '0, acc);
        idle(2);
        // Single word followed by an underrun.
        send_word(8'hA5);
        idle(6);
        // Back-to-back words with D_VALID held high.
        send_word(8'hA5);
        send_word(8'h3C);
        idle(8);
        // CE freeze on the second bit, with a word offered during the freeze.
        send_word(8'hA5);
        idle(1);
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 8'h3C, acc);
        idle(6);
        // Reset mid-word at cnt = 2.
        send_word(8'hA5);
        idle(2);
        cycle(1'b0, 1'b1, 1'b0, '0, acc);
        idle(6);
        // Enough single-word underruns to saturate the optional counter.
        repeat (300) begin
            send_word(W'($urandom));
            idle(RT);
        end
`ifdef X_OSER_UNDERRUN_CNT_EN
        check("ucnt_saturated", {24'd0, ucnt_l}, 32'hFF);
`endif
        // Randomised CE, D_VALID, data and occasional reset.
        for (int i = 0; i < 2500; i++) begin
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) < 6, W'($urandom), acc);
        end
        idle(RT + 3);
        check("sb_lsb_drained", sb_l.size(), 0);
        check("sb_msb_drained", sb_m.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
